ex_hilo_muldiv: RTL and testbench

//   Parametrised multi-cycle multiply/divide unit for the EX stage. It feeds the HI/LO

---
 rtl/ex_hilo_muldiv_pkg.sv | 22 ++
 rtl/ex_hilo_muldiv_div_iter.sv | 64 ++++++
 rtl/ex_hilo_muldiv.sv | 153 +++++++++++++++
 tb/tb_ex_hilo_muldiv.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_hilo_muldiv_pkg.sv
// Shared types for the EX-stage HI/LO multiply/divide unit: op and FSM state encodings
// plus the default datapath width.
package ex_hilo_muldiv_pkg;

  localparam int RegDataWidth = 32;

  typedef enum logic [1:0] {
    MULDIV_MULT  = 2'b00,
    MULDIV_MULTU = 2'b01,
    MULDIV_DIV   = 2'b10,
    MULDIV_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DZ
  } muldiv_state_e;

endpackage

// File: rtl/ex_hilo_muldiv_div_iter.sv
// Unsigned restoring divider core: one quotient bit per cycle, DATA_W cycles after start,
// then a one-cycle valid pulse with quotient/remainder held until the next start.
module muldiv_div_iter #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_q,
  output logic [DATA_W-1:0] o_r,
  output logic              o_valid
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_rem, r_quo, r_dvs;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_run, r_valid;

  logic [DATA_W:0]   w_shift;
  logic              w_ge;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign w_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_abort) begin
        r_run <= 1'b0;
      end else if (i_start) begin
        r_rem <= '0;
        r_quo <= i_a;
        r_dvs <= i_b;
        r_cnt <= CNT_W'(DATA_W - 1);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= w_ge ? DATA_W'(w_shift - {1'b0, r_dvs}) : w_shift[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], w_ge};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          r_run   <= 1'b0;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign o_q     = r_quo;
  assign o_r     = r_rem;
  assign o_valid = r_valid;

endmodule

// File: rtl/ex_hilo_muldiv.sv
// EX-stage multi-cycle multiply/divide unit feeding HI/LO: pipelined multiplier,
// iterative divider with sign fix-up, stall request and one-cycle HI/LO write pulse.
module ex_hilo_muldiv
  import ex_hilo_muldiv_pkg::*;
#(
  parameter int DATA_W     = RegDataWidth,
  parameter int MUL_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_src_a,
  input  logic [DATA_W-1:0] i_src_b,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_stall_req,
  output logic              o_done,
  output logic              o_we_hi,
  output logic              o_we_lo,
  output logic [DATA_W-1:0] o_hi_out,
  output logic [DATA_W-1:0] o_lo_out,
  output logic              o_div_by_zero
);

  muldiv_state_e       r_state;
  logic [1:0]          r_cnt;
  logic                r_done, r_dbz, r_q_neg, r_r_neg;
  logic [DATA_W-1:0]   r_hi, r_lo;

  muldiv_op_e          w_op;
  logic                w_is_div, w_signed, w_a_neg, w_b_neg, w_b_zero;
  logic                w_accept, w_div_start, w_div_valid;
  logic [DATA_W-1:0]   w_a_abs, w_b_abs, w_div_q, w_div_r, w_q_fix, w_r_fix;
  logic [2*DATA_W-1:0] w_prod, w_mul_res;

  assign w_op        = muldiv_op_e'(i_op);
  assign w_is_div    = (w_op == MULDIV_DIV) || (w_op == MULDIV_DIVU);
  assign w_signed    = (w_op == MULDIV_MULT) || (w_op == MULDIV_DIV);
  assign w_a_neg     = w_signed & i_src_a[DATA_W-1];
  assign w_b_neg     = w_signed & i_src_b[DATA_W-1];
  assign w_b_zero    = (i_src_b == '0);
  assign w_accept    = i_start & ~i_flush & (r_state == ST_IDLE);
  assign w_div_start = w_accept & w_is_div & ~w_b_zero;
  assign w_a_abs     = w_a_neg ? (-i_src_a) : i_src_a;
  assign w_b_abs     = w_b_neg ? (-i_src_b) : i_src_b;

  // Sign-extending both operands lets one modulo-2^(2W) multiplier serve MULT and MULTU.
  assign w_prod = {{DATA_W{w_a_neg}}, i_src_a} * {{DATA_W{w_b_neg}}, i_src_b};

  if (MUL_STAGES == 1) begin : g_mul_direct
    assign w_mul_res = w_prod;
  end else begin : g_mul_pipe
    logic [2*DATA_W-1:0] r_pipe [MUL_STAGES-1];
    // NOTE: pure datapath pipeline with no reset; the FSM alone decides when a stage is meaningful.
    always_ff @(posedge i_clk) begin
      r_pipe[0] <= w_prod;
      for (int i = 1; i < MUL_STAGES - 1; i++) r_pipe[i] <= r_pipe[i-1];
    end
    assign w_mul_res = r_pipe[MUL_STAGES-2];
  end

  muldiv_div_iter #(.DATA_W(DATA_W)) u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_div_start),
    .i_abort (i_flush),
    .i_a     (w_a_abs),
    .i_b     (w_b_abs),
    .o_q     (w_div_q),
    .o_r     (w_div_r),
    .o_valid (w_div_valid)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_q_fix = w_div_q;
    w_r_fix = w_div_r;
    if (r_q_neg) w_q_fix = -w_div_q;
    if (r_r_neg) w_r_fix = -w_div_r;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (i_flush) begin
        r_state <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: if (w_accept) begin
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
            if (!w_is_div) begin
              r_state <= ST_MUL;
              r_cnt   <= 2'(MUL_STAGES - 1);
              if (MUL_STAGES == 1) begin
                r_done       <= 1'b1;
                {r_hi, r_lo} <= w_prod;
              end
            end else if (w_b_zero) begin
              r_state <= ST_DZ;
              r_done  <= 1'b1;
              r_dbz   <= 1'b1;
              r_hi    <= i_src_a;
              r_lo    <= '1;
            end else begin
              r_state <= ST_DIV;
            end
          end
          ST_MUL: if (r_cnt == 2'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
            if (r_cnt == 2'd1) begin
              r_done       <= 1'b1;
              {r_hi, r_lo} <= w_mul_res;
            end
          end
          ST_DIV: if (w_div_valid) begin
            r_state <= ST_FIX;
            r_done  <= 1'b1;
            r_hi    <= w_r_fix;
            r_lo    <= w_q_fix;
          end
          ST_FIX, ST_DZ: r_state <= ST_IDLE;
          default:       r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // A flush landing on the done cycle must not let the HI/LO write through.
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done & ~i_flush;
  assign o_we_hi       = o_done;
  assign o_we_lo       = o_done;
  assign o_div_by_zero = r_dbz & ~i_flush;
  assign o_stall_req   = o_busy | (i_start & ~o_done);
  assign o_hi_out      = r_hi;
  assign o_lo_out      = r_lo;

endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// Scoreboard bench for ex_hilo_muldiv: stimulus pushes model results, a negedge monitor
// pops and compares them whenever done is seen.
module tb_ex_hilo_muldiv;

  localparam int DATA_W     = 32;
  localparam int MUL_STAGES = 2;
  localparam int DIV_LAT    = DATA_W + 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_start, i_flush;
  logic [1:0]  i_op;
  logic [31:0] i_src_a, i_src_b;
  logic        o_busy, o_stall_req, o_done, o_we_hi, o_we_lo, o_div_by_zero;
  logic [31:0] o_hi_out, o_lo_out;

  ex_hilo_muldiv #(.DATA_W(DATA_W), .MUL_STAGES(MUL_STAGES)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_src_a       (i_src_a),
    .i_src_b       (i_src_b),
    .i_flush       (i_flush),
    .o_busy        (o_busy),
    .o_stall_req   (o_stall_req),
    .o_done        (o_done),
    .o_we_hi       (o_we_hi),
    .o_we_lo       (o_we_lo),
    .o_hi_out      (o_hi_out),
    .o_lo_out      (o_lo_out),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain arithmetic on the architectural rules, latency in cycles after accept.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    longint          p;
    longint unsigned pu;
    int              sa, sb;
    sa    = $signed(a);
    sb    = $signed(b);
    e.hi  = '0;
    e.lo  = '0;
    e.dbz = 1'b0;
    e.cyc = MUL_STAGES;
    case (op)
      2'b00: begin
        p = longint'(sa) * longint'(sb);
        {e.hi, e.lo} = p;
      end
      2'b01: begin
        pu = {32'h0, a} * {32'h0, b};
        {e.hi, e.lo} = pu;
      end
      default: begin
        e.cyc = DIV_LAT;
        if (b == 32'h0) begin
          e.lo  = '1;
          e.hi  = a;
          e.dbz = 1'b1;
          e.cyc = 1;
        end else if (op == 2'b10) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = a;
            e.hi = '0;
          end else begin
            e.lo = sa / sb;
            e.hi = sa % sb;
          end
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Leaves the caller just after a rising edge with the unit idle.
  task automatic wait_idle();
    int n = 0;
    @(posedge i_clk); #1;
    while (o_busy && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("wait_idle", 64'(o_busy), 64'(0));
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    i_start = 1'b1;
    i_op    = op;
    i_src_a = a;
    i_src_b = b;
    e       = model(op, a, b);
    e.cyc   = e.cyc + cyc;
    sb_q.push_back(e);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_op    = 2'($urandom_range(0, 3));
    i_src_a = $urandom;
    i_src_b = $urandom;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'(o_done), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("hi_out", 64'(o_hi_out), 64'(e.hi));
          check("lo_out", 64'(o_lo_out), 64'(e.lo));
          check("div_by_zero", 64'(o_div_by_zero), 64'(e.dbz));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("we_hi_lo", 64'({o_we_hi, o_we_lo}), 64'(2'b11));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          t0;
    logic [31:0] pre_hi, pre_lo;
    logic [1:0]  op;
    logic [31:0] a, b;

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_flush = 1'b0;
    i_op    = 2'b00;
    i_src_a = '0;
    i_src_b = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_ctrl", 64'({o_busy, o_done, o_we_hi, o_we_lo, o_div_by_zero, o_stall_req}), 64'(0));
    check("reset_hi", 64'(o_hi_out), 64'(0));
    check("reset_lo", 64'(o_lo_out), 64'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Reference vectors and corner cases.
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    issue(2'b11, 32'd100, 32'd7);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b11, 32'd5, 32'd0);
    issue(2'b10, 32'd9, 32'd0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);

    // Flush mid-divide: no write, HI/LO kept, new MULT two cycles later runs normally.
    wait_idle();
    pre_hi  = o_hi_out;
    pre_lo  = o_lo_out;
    t0      = cyc;
    i_start = 1'b1;
    i_op    = 2'b10;
    i_src_a = 32'h1234_5678;
    i_src_b = 32'd3;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    while (cyc < t0 + 10) begin
      @(posedge i_clk); #1;
    end
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    check("flush_idle", 64'(o_busy), 64'(0));
    check("flush_hi_kept", 64'(o_hi_out), 64'(pre_hi));
    check("flush_lo_kept", 64'(o_lo_out), 64'(pre_lo));
    @(posedge i_clk); #1;
    check("flush_restart_cycle", 64'(cyc), 64'(t0 + 12));
    begin
      exp_t e;
      e       = model(2'b00, 32'hFFFF_FF00, 32'd300);
      e.cyc   = e.cyc + cyc;
      sb_q.push_back(e);
      i_start = 1'b1;
      i_op    = 2'b00;
      i_src_a = 32'hFFFF_FF00;
      i_src_b = 32'd300;
      @(posedge i_clk); #1;
      i_start = 1'b0;
    end

    // Start held through busy and the done cycle: only the first op runs.
    wait_idle();
    begin
      exp_t e;
      t0      = cyc;
      e       = model(2'b10, 32'hDEAD_BEEF, 32'd1234);
      e.cyc   = t0 + e.cyc;
      sb_q.push_back(e);
      i_start = 1'b1;
      i_op    = 2'b10;
      i_src_a = 32'hDEAD_BEEF;
      i_src_b = 32'd1234;
      #1;
      check("stall_on_start", 64'(o_stall_req), 64'(1));
      for (int k = 1; k <= DIV_LAT; k++) begin
        @(posedge i_clk); #1;
        i_src_a = $urandom;
        i_src_b = $urandom;
        #1;
        check("stall_while_busy", 64'(o_stall_req), 64'(1));
      end
      @(posedge i_clk); #1;
      i_start = 1'b0;
      check("start_in_done_ignored", 64'(o_busy), 64'(0));
    end

    // Flush coinciding with the done cycle suppresses done and the write enables.
    wait_idle();
    i_start = 1'b1;
    i_op    = 2'b01;
    i_src_a = 32'd77;
    i_src_b = 32'd88;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(posedge i_clk); #1;
    i_flush = 1'b1;
    #1;
    check("flush_done_suppressed", 64'({o_done, o_we_hi, o_we_lo}), 64'(0));
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    check("flush_done_idle", 64'(o_busy), 64'(0));

    // Async reset in the middle of a divide.
    issue(2'b01, 32'h0001_0001, 32'h0000_0003);
    wait_idle();
    t0      = cyc;
    i_start = 1'b1;
    i_op    = 2'b11;
    i_src_a = 32'hFFFF_0000;
    i_src_b = 32'd17;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    while (cyc < t0 + 5) begin
      @(posedge i_clk); #1;
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({o_busy, o_done, o_we_hi, o_we_lo, o_div_by_zero, o_stall_req}), 64'(0));
    check("async_rst_hi", 64'(o_hi_out), 64'(0));
    check("async_rst_lo", 64'(o_lo_out), 64'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Randomized operations with operands scrambled after accept.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       begin a = 32'h8000_0000; b = '1; end
        2:       b = 32'($urandom_range(1, 15));
        3:       a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      issue(op, a, b);
    end

    begin
      int n = 0;
      while (sb_q.size() != 0 && n < 300) begin
        @(posedge i_clk);
        n++;
      end
    end
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    repeat (40) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
